// File: rtl/sobel_pkg.sv
// Shared constants and FSM state type for the Sobel window-position generator.
package sobel_pkg;

  localparam int EDGE_TOP    = 3;
  localparam int EDGE_BOTTOM = 2;
  localparam int EDGE_LEFT   = 1;
  localparam int EDGE_RIGHT  = 0;

  localparam logic BORDER_ZERO = 1'b0;
  localparam logic BORDER_REP  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/sobel_frame_counter.sv
// Raster row/column counter with enable; wraps at the frame end and flags the last pixel.
module sobel_frame_counter
  import sobel_pkg::*;
#(
  parameter int COLNUM = 1920,
  parameter int ROWNUM = 1080,
  parameter int CNT_W  = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] row,
  output logic [CNT_W-1:0] col,
  output logic             last
);

  localparam logic [CNT_W-1:0] COL_MAX = CNT_W'(COLNUM - 1);
  localparam logic [CNT_W-1:0] ROW_MAX = CNT_W'(ROWNUM - 1);

  assign last = (row == ROW_MAX) && (col == COL_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (col == COL_MAX) begin
        col <= '0;
        row <= (row == ROW_MAX) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sobel_window_position_gen.sv
// Window-centre position generator: lags the input raster by R rows + R columns and
// tags each centre with its border mask, pad/replicate flags and frame markers.
//
//   state    | meaning
//   ST_IDLE  | waiting for the first pixel of a frame; latches border mode on accept
//   ST_FILL  | accepting the first L pixels, no output yet
//   ST_RUN   | one output position per accepted pixel
//   ST_DRAIN | input closed; emits the remaining L centres up to eof
module sobel_window_position_gen
  import sobel_pkg::*;
#(
  parameter int COLNUM = 1920,
  parameter int ROWNUM = 1080,
  parameter int KSIZE  = 3,
  parameter int CNT_W  = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_border_mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_row,
  output logic [CNT_W-1:0] out_col,
  output logic [3:0]       out_edge,
  output logic             out_cov,
  output logic             out_zero,
  output logic             out_rep,
  output logic             out_sof,
  output logic             out_eol,
  output logic             out_eof
);

  localparam int R   = (KSIZE - 1) / 2;
  localparam int LAG = R * COLNUM + R;
  localparam logic [CNT_W-1:0] R_C      = CNT_W'(R);
  localparam logic [CNT_W-1:0] R_M1     = CNT_W'((R == 0) ? 0 : R - 1);
  localparam logic [CNT_W-1:0] BOT_LIM  = CNT_W'(ROWNUM - 1 - R);
  localparam logic [CNT_W-1:0] RGT_LIM  = CNT_W'(COLNUM - 1 - R);
  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(COLNUM - 1);

  state_t           state, state_nxt;
  logic             armed, mode_q, cur_mode;
  logic             can_load, accept, load, fill_done;
  logic [CNT_W-1:0] in_row, in_col, c_row, c_col;
  logic             in_last, c_last;
  logic [3:0]       edge_mask;

  sobel_frame_counter #(.COLNUM(COLNUM), .ROWNUM(ROWNUM), .CNT_W(CNT_W)) u_in_cnt (
    .clk(clk), .rst(rst), .en(accept), .row(in_row), .col(in_col), .last(in_last)
  );

  sobel_frame_counter #(.COLNUM(COLNUM), .ROWNUM(ROWNUM), .CNT_W(CNT_W)) u_c_cnt (
    .clk(clk), .rst(rst), .en(load), .row(c_row), .col(c_col), .last(c_last)
  );

  // The L-th pixel of a frame sits at raster index L-1, i.e. (R, R-1).
  assign fill_done = (in_row == R_C) && (in_col == R_M1);
  assign can_load  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign cur_mode  = (state == ST_IDLE) ? cfg_border_mode : mode_q;

  always_comb begin
    edge_mask              = '0;
    edge_mask[EDGE_TOP]    = c_row < R_C;
    edge_mask[EDGE_BOTTOM] = c_row > BOT_LIM;
    edge_mask[EDGE_LEFT]   = c_col < R_C;
    edge_mask[EDGE_RIGHT]  = c_col > RGT_LIM;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    load      = 1'b0;
    case (state)
      ST_IDLE: begin
        // With zero lag the first pixel loads an output, so it must respect backpressure.
        in_ready = armed && ((LAG > 0) || can_load);
        if (in_valid && in_ready) begin
          if (LAG > 0) begin
            state_nxt = ST_FILL;
          end else begin
            load      = 1'b1;
            state_nxt = in_last ? ST_IDLE : ST_RUN;
          end
        end
      end
      ST_FILL: begin
        in_ready = 1'b1;
        if (in_valid && fill_done) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        in_ready = can_load;
        if (in_valid && in_ready) begin
          load = 1'b1;
          if (in_last) state_nxt = (LAG > 0) ? ST_DRAIN : ST_IDLE;
        end
      end
      ST_DRAIN: begin
        load = can_load;
        if (can_load && c_last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      armed  <= 1'b0;
      mode_q <= BORDER_ZERO;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
      if (state == ST_IDLE && accept) mode_q <= cfg_border_mode;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
      out_edge  <= '0;
      out_cov   <= 1'b0;
      out_zero  <= 1'b0;
      out_rep   <= 1'b0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_row   <= c_row;
      out_col   <= c_col;
      out_edge  <= edge_mask;
      out_cov   <= (edge_mask == 4'd0);
      out_zero  <= (edge_mask != 4'd0) && (cur_mode == BORDER_ZERO);
      out_rep   <= (edge_mask != 4'd0) && (cur_mode == BORDER_REP);
      out_sof   <= (c_row == '0) && (c_col == '0);
      out_eol   <= (c_col == COL_LAST);
      out_eof   <= c_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sobel_window_position_gen.sv
// Directed bench: an 8x6 frame through KSIZE=3 and KSIZE=5 instances sharing clock,
// reset, border mode and out_ready.
module tb_sobel_window_position_gen;

  logic        clk = 1'b0;
  logic        rst, cfg, out_ready, rand_rdy;
  logic        iv    [2];
  logic        ir    [2];
  logic        ov    [2];
  logic        ocov  [2];
  logic        ozero [2];
  logic        orep  [2];
  logic        osof  [2];
  logic        oeol  [2];
  logic        oeof  [2];
  logic [11:0] orow  [2];
  logic [11:0] ocol  [2];
  logic [3:0]  oedge [2];

  int n_chk = 0;
  int n_pass = 0;
  int acc [2], tgt [2], outs [2], er [2], ec [2], fm [2], first_acc [2], drain_n [2];
  logic        prev_stall [2];
  logic        prev_acc   [2];
  logic        seen       [2];
  logic [33:0] held       [2];
  logic [33:0] rec        [2][48];

  always #5 clk = ~clk;

  sobel_window_position_gen #(.COLNUM(8), .ROWNUM(6), .KSIZE(3), .CNT_W(12)) dut_k3 (
    .clk(clk), .rst(rst), .cfg_border_mode(cfg), .in_valid(iv[0]), .in_ready(ir[0]),
    .out_valid(ov[0]), .out_ready(out_ready), .out_row(orow[0]), .out_col(ocol[0]),
    .out_edge(oedge[0]), .out_cov(ocov[0]), .out_zero(ozero[0]), .out_rep(orep[0]),
    .out_sof(osof[0]), .out_eol(oeol[0]), .out_eof(oeof[0])
  );

  sobel_window_position_gen #(.COLNUM(8), .ROWNUM(6), .KSIZE(5), .CNT_W(12)) dut_k5 (
    .clk(clk), .rst(rst), .cfg_border_mode(cfg), .in_valid(iv[1]), .in_ready(ir[1]),
    .out_valid(ov[1]), .out_ready(out_ready), .out_row(orow[1]), .out_col(ocol[1]),
    .out_edge(oedge[1]), .out_cov(ocov[1]), .out_zero(ozero[1]), .out_rep(orep[1]),
    .out_sof(osof[1]), .out_eol(oeol[1]), .out_eof(oeof[1])
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [33:0] cur_out(input int d);
    return {orow[d], ocol[d], oedge[d], ocov[d], ozero[d], orep[d], osof[d], oeol[d], oeof[d]};
  endfunction

  // Expected fields for centre (r,c) of an 8x6 frame with R = d+1.
  function automatic logic [33:0] exp_out(input int d, input int r, input int c, input logic m);
    int rr;
    logic [3:0] e;
    rr = d + 1;
    e = {r < rr, r > 5 - rr, c < rr, c > 7 - rr};
    return {12'(r), 12'(c), e, e == 4'd0, (e != 4'd0) && !m, (e != 4'd0) && m,
            (r == 0) && (c == 0), c == 7, (r == 5) && (c == 7)};
  endfunction

  function automatic logic all_done(input int n);
    return (acc[0] == tgt[0]) && (acc[1] == tgt[1]) && (outs[0] == n) && (outs[1] == n);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      er[d] = 0; ec[d] = 0; fm[d] = 3; outs[d] = 0;
      prev_stall[d] = 1'b0; prev_acc[d] = 1'b0; tgt[d] = acc[d];
    end
  endtask

  // Drive at the falling edge, then sample what the next rising edge will consume.
  task automatic tick(input logic r);
    logic [33:0] cur;
    logic new_out;
    @(negedge clk);
    rst = r;
    for (int d = 0; d < 2; d++) iv[d] = (acc[d] < tgt[d]);
    out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    if (!r) begin
      for (int d = 0; d < 2; d++) begin
        cur = cur_out(d);
        if (prev_stall[d]) chk("hold", 64'({ov[d], cur}), 64'({1'b1, held[d]}));
        new_out = ov[d] && !prev_stall[d];
        if (new_out && !seen[d]) begin
          seen[d] = 1'b1;
          first_acc[d] = acc[d];
        end
        if (new_out && !prev_acc[d]) drain_n[d]++;
        if (ov[d] && out_ready) begin
          chk("pos", 64'(cur), 64'(exp_out(d, er[d], ec[d], fm[d] == 1)));
          if (fm[d] == 0 && outs[d] < 48) rec[d][outs[d]] = cur;
          outs[d]++;
          ec[d]++;
          if (ec[d] == 8) begin
            ec[d] = 0; er[d]++;
            if (er[d] == 6) begin er[d] = 0; fm[d]++; end
          end
        end
        prev_stall[d] = ov[d] && !out_ready;
        held[d] = cur;
        prev_acc[d] = iv[d] && ir[d];
        if (iv[d] && ir[d]) acc[d]++;
      end
    end
  endtask

  initial begin
    rst = 1'b1; cfg = 1'b0; out_ready = 1'b0; rand_rdy = 1'b0;
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0; acc[d] = 0; tgt[d] = 0; outs[d] = 0; er[d] = 0; ec[d] = 0; fm[d] = 0;
      first_acc[d] = -1; drain_n[d] = 0; prev_stall[d] = 1'b0; prev_acc[d] = 1'b0;
      seen[d] = 1'b0; held[d] = '0;
    end
    tick(1'b1);
    tick(1'b1);
    tick(1'b0);
    for (int d = 0; d < 2; d++) chk("rst_state", 64'({ov[d], ir[d], cur_out(d)}), 64'(0));
    tick(1'b0);
    for (int d = 0; d < 2; d++) chk("idle_ready", 64'(ir[d]), 64'(1));

    // Frame 0: continuous valid/ready, zero padding.
    tgt[0] = 48; tgt[1] = 48;
    for (int i = 0; i < 200 && acc[0] < 48; i++) tick(1'b0);
    tick(1'b0);
    chk("ready_drop_k3", 64'(ir[0]), 64'(0));
    chk("ready_drop_k5", 64'(ir[1]), 64'(0));
    for (int i = 0; i < 200 && !all_done(48); i++) tick(1'b0);
    chk("p0_done", 64'(all_done(48)), 64'(1));
    chk("first_acc_k3", 64'(first_acc[0]), 64'(10));
    chk("first_acc_k5", 64'(first_acc[1]), 64'(19));
    chk("drain_k3", 64'(drain_n[0]), 64'(9));
    chk("drain_k5", 64'(drain_n[1]), 64'(18));
    chk("k3_0_0", 64'(rec[0][0]),  64'({12'd0, 12'd0, 4'b1010, 6'b010100}));
    chk("k3_1_7", 64'(rec[0][15]), 64'({12'd1, 12'd7, 4'b0001, 6'b010010}));
    chk("k3_2_3", 64'(rec[0][19]), 64'({12'd2, 12'd3, 4'b0000, 6'b100000}));
    chk("k3_5_7", 64'(rec[0][47]), 64'({12'd5, 12'd7, 4'b0101, 6'b010011}));
    chk("k5_1_1", 64'(rec[1][9]),  64'({12'd1, 12'd1, 4'b1010, 6'b010000}));
    chk("k5_2_2", 64'(rec[1][18]), 64'({12'd2, 12'd2, 4'b0000, 6'b100000}));
    chk("k5_5_7", 64'(rec[1][47]), 64'({12'd5, 12'd7, 4'b0101, 6'b010011}));

    // Frames 1 and 2 back-to-back under random backpressure; replicate then zero.
    cfg = 1'b1; rand_rdy = 1'b1;
    tgt[0] = 144; tgt[1] = 144;
    for (int i = 0; i < 3000 && !all_done(144); i++) begin
      tick(1'b0);
      if (acc[0] >= 72) cfg = 1'b0;
    end
    chk("p12_done", 64'(all_done(144)), 64'(1));
    chk("frames_k3", 64'(fm[0]), 64'(3));
    chk("frames_k5", 64'(fm[1]), 64'(3));

    // Reset while both instances are draining frame 3.
    rand_rdy = 1'b0;
    tgt[0] = 192; tgt[1] = 192;
    for (int i = 0; i < 200 && acc[0] < 192; i++) tick(1'b0);
    tick(1'b0);
    tick(1'b0);
    chk("in_drain_k5", 64'({ov[1], ir[1]}), 64'(2'b10));
    tick(1'b1);
    model_reset();
    tick(1'b0);
    for (int d = 0; d < 2; d++) chk("post_rst", 64'({ov[d], ir[d]}), 64'(0));
    tick(1'b0);
    for (int d = 0; d < 2; d++) chk("post_rst_idle", 64'(ir[d]), 64'(1));
    tgt[0] = acc[0] + 48; tgt[1] = acc[1] + 48;
    for (int i = 0; i < 300 && !all_done(48); i++) tick(1'b0);
    chk("fresh_done", 64'(all_done(48)), 64'(1));
    chk("fresh_frame_k3", 64'(fm[0]), 64'(4));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sobel_window_position_gen.md
Name: sobel_window_position_gen

Overview:
- Frame-aware window-position generator for the Sobel/convolution pipeline; next generation of the fixed 3x3 position calculator.
- Counts accepted input pixels and emits exactly one output position per frame pixel.
- Each output position is the window centre, lagging the input by R rows + R columns (R=(KSIZE-1)/2), tagged with border edge mask, pad/zero/replicate flags and frame markers.
- Sits between the line-buffer write side and the convolution datapath; downstream uses the flags to select convolve, zero or replicate per pixel.

Parameters:
- COLNUM, 1920, active pixels per row (>= KSIZE)
- ROWNUM, 1080, active rows per frame (>= KSIZE)
- KSIZE, 3, window size; odd, 1..7
- CNT_W, 12, counter width; must hold max(COLNUM,ROWNUM)-1

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cfg_border_mode  in  1  0=zero pad, 1=replicate; sampled when the first pixel of a frame is accepted
- in_valid  in  1  upstream pixel present
- in_ready  out  1  pixel accepted when in_valid&&in_ready
- out_valid  out  1  output position valid
- out_ready  in  1  downstream accepts position
- out_row  out  CNT_W  centre row
- out_col  out  CNT_W  centre column
- out_edge  out  4  {top,bottom,left,right} window exceeds frame on that side
- out_cov  out  1  out_edge==0, full convolution
- out_zero  out  1  out_edge!=0 && latched mode==0
- out_rep  out  1  out_edge!=0 && latched mode==1
- out_sof  out  1  centre (0,0)
- out_eol  out  1  out_col==COLNUM-1
- out_eof  out  1  centre (ROWNUM-1,COLNUM-1)

Behaviour:
- Reset: all outputs 0 except in_ready=0; counters 0; state IDLE; latched mode 0. Takes effect next edge; mid-frame reset discards all state, with no partial drain.
- Lag L = R*COLNUM + R pixels.
- Input counter (in_row,in_col) increments on every accepted pixel; col wraps at COLNUM-1 into row++; row wraps at ROWNUM-1 to 0.
- Centre counter (c_row,c_col) has identical wrap rules and advances on each output load.
- Output register: loads when (!out_valid || out_ready) and a position is due. out_valid holds with all fields stable until out_ready; no bubbles are inserted when out_ready stays high.
- FSM:
  - IDLE: in_ready=1. Accept -> latch mode. Go to FILL if L>0, else RUN (the same pixel produces an output).
  - FILL: in_ready=1; no output. On the L-th accepted pixel go to RUN.
  - RUN: in_ready = !out_valid || out_ready. Each accepted pixel loads one output position. On accepting the last frame pixel (in_row=ROWNUM-1, in_col=COLNUM-1): go to DRAIN if L>0, else IDLE.
  - DRAIN: in_ready=0. Each output load produces the next centre with no input. After loading the eof position, go to IDLE. A new frame is not accepted until the eof position has been loaded.
- Edge mask: top = c_row<R; bottom = c_row>ROWNUM-1-R; left = c_col<R; right = c_col>COLNUM-1-R.
- Comparisons are unsigned; R and the limits are elaboration constants.
- KSIZE=1: L=0, edge always 0, out_cov always 1; the block is a pure handshake pass-through with coordinates.
- Back-to-back frames: the IDLE accept may coincide with the final DRAIN handshake, so the gap is zero cycles when L=0.
- A mode change mid-frame is ignored until the next frame start.
- Each frame yields exactly COLNUM*ROWNUM outputs and exactly one sof and one eof.

Decomposition:
- Package sobel_pkg: edge-bit index constants (EDGE_TOP=3, EDGE_BOTTOM=2, EDGE_LEFT=1, EDGE_RIGHT=0), border-mode constants (BORDER_ZERO=0, BORDER_REP=1), FSM state enum.
- One sub-module, sobel_frame_counter (row/col counter with enable, wrap and last-pixel flag), instantiated twice: input side and centre side.

Test Plan:
- COLNUM=8, ROWNUM=6, KSIZE=3, continuous valid/ready, 48 pixels:
  - the first output appears with the 10th accept: (0,0), edge=4'b1010, sof=1, zero=1;
  - in_ready drops after the 48th accept;
  - 9 drain outputs follow; the last is (5,7), edge=4'b0101, eof=1;
  - 48 outputs total.
- Same config, interior check: centre (2,3) -> edge=0, cov=1, zero=0, rep=0; centre (1,7) -> edge=4'b0000? No: (1,7) is right only, edge=4'b0001.
- Random out_ready (50%), 2 frames back-to-back:
  - out fields stay stable while out_valid&&!out_ready;
  - no position is lost or duplicated; the sequence is raster-ordered per frame.
- cfg_border_mode=1 at frame 1 start, toggled to 0 mid-frame: all frame-1 border outputs have rep=1, zero=0; frame 2 border outputs have zero=1.
- KSIZE=5, COLNUM=8, ROWNUM=6: L=18; (1,1) has edge=4'b1010; (2,2) has cov=1; 18 drain outputs.
- rst asserted during DRAIN: next cycle out_valid=0, in_ready=0; the following cycle in_ready=1 (IDLE); a fresh frame starts at sof (0,0).
